// File: rtl/tor_slot_sync_rx.sv
// ToR control-channel receiver: parses OCS controller frames and rebuilds
// the slot schedule (slot id, boundaries, tx window) from TIME_SYNC frames.
module tor_slot_sync_rx #(
   parameter logic [47:0] P_MY_TOR_MAC   = 48'h8D_BC_5C_4A_00_00,
   parameter logic [15:0] P_CTRL_TYPE    = 16'h88B5,
   parameter logic [31:0] P_SLOT_LEN     = 32'h0000_0832,
   parameter logic [31:0] P_CONFIG_DELAY = 32'h0000_007D,
   parameter logic [31:0] P_SYNC_MARGIN  = 32'h0000_0010
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [63:0] i_rx_axis_data,
   input  logic [7:0]  i_rx_axis_keep,
   input  logic        i_rx_axis_valid,
   input  logic        i_rx_axis_last,
   input  logic        i_rx_axis_user,
   output logic        o_sim_start,
   output logic [7:0]  o_slot_id,
   output logic        o_slot_start,
   output logic        o_slot_end,
   output logic        o_tx_en,
   output logic        o_sync_lost,
   output logic [15:0] o_frame_err_cnt
);

   localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
   localparam logic [7:0]  OP_SIM_START = 8'h01;
   localparam logic [7:0]  OP_TIME_SYNC = 8'h02;
   localparam logic [31:0] ACT_LAST     = P_SLOT_LEN - 32'd1;
   localparam logic [31:0] GRD_LAST     = P_CONFIG_DELAY + P_SYNC_MARGIN - 32'd1;

   typedef enum logic [1:0] {HDR0, HDR1, PAD} prs_t;
   typedef enum logic [1:0] {IDLE, WAIT_SYNC, ACTIVE, GUARD} slot_t;

   prs_t        prs_q, prs_d;
   logic        dst_ok_q, dst_ok_d;
   logic        type_ok_q, type_ok_d;
   logic [7:0]  op_q, op_d;
   logic [7:0]  sid_q, sid_d;
   logic [15:0] err_q, err_d;

   slot_t       st_q, st_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  id_q, id_d;
   logic        sim_q, sim_d;
   logic        lost_q, lost_d;
   logic        start_q, start_d;
   logic        slot_end;

   logic        beat_dst_ok, beat_type_ok;
   logic        f_dst, f_type, f_len;
   logic [7:0]  f_op, f_sid;
   logic        frame_end, f_op_known, f_good, frame_ok, frame_bad;
   logic        commit_sim, commit_sync;

   assign beat_dst_ok  = (i_rx_axis_data[63:16] == P_MY_TOR_MAC) ||
                         (i_rx_axis_data[63:16] == BCAST_MAC);
   assign beat_type_ok = (i_rx_axis_data[31:16] == P_CTRL_TYPE);

   always_comb begin
      prs_d     = prs_q;
      dst_ok_d  = dst_ok_q;
      type_ok_d = type_ok_q;
      op_d      = op_q;
      sid_d     = sid_q;
      if (i_rx_axis_valid) begin
         unique case (prs_q)
            HDR0: begin
               dst_ok_d = beat_dst_ok;
               prs_d    = i_rx_axis_last ? HDR0 : HDR1;
            end
            HDR1: begin
               type_ok_d = beat_type_ok;
               op_d      = i_rx_axis_data[15:8];
               sid_d     = i_rx_axis_data[7:0];
               prs_d     = i_rx_axis_last ? HDR0 : PAD;
            end
            PAD: begin
               if (i_rx_axis_last) prs_d = HDR0;
            end
            default: prs_d = HDR0;
         endcase
      end
   end

   // Header fields as seen by a frame ending on this beat; a frame ending
   // in HDR1 must carry the whole second header beat.
   always_comb begin
      f_dst  = dst_ok_q;
      f_type = type_ok_q;
      f_op   = op_q;
      f_sid  = sid_q;
      f_len  = 1'b1;
      unique case (prs_q)
         HDR0: begin
            f_dst = beat_dst_ok;
            f_len = 1'b0;
         end
         HDR1: begin
            f_type = beat_type_ok;
            f_op   = i_rx_axis_data[15:8];
            f_sid  = i_rx_axis_data[7:0];
            f_len  = (i_rx_axis_keep == 8'hFF);
         end
         default: f_len = 1'b1;
      endcase
   end

   assign frame_end   = i_rx_axis_valid && i_rx_axis_last;
   assign f_op_known  = (f_op == OP_SIM_START) || (f_op == OP_TIME_SYNC);
   assign f_good      = f_len && f_type && f_op_known && !i_rx_axis_user;
   assign frame_ok    = frame_end && f_dst && f_good;
   assign frame_bad   = frame_end && f_dst && !f_good;
   assign commit_sim  = frame_ok && (f_op == OP_SIM_START);
   assign commit_sync = frame_ok && (f_op == OP_TIME_SYNC);

   always_comb begin
      err_d = err_q;
      if (frame_bad && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
   end

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      sim_d    = sim_q;
      lost_d   = lost_q;
      start_d  = 1'b0;
      slot_end = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (commit_sim) begin
               sim_d = 1'b1;
               st_d  = WAIT_SYNC;
            end
         end
         WAIT_SYNC: begin
            if (commit_sync) begin
               id_d    = f_sid;
               cnt_d   = 32'd0;
               lost_d  = 1'b0;
               start_d = 1'b1;
               st_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == ACT_LAST) begin
               slot_end = 1'b1;
               cnt_d    = 32'd0;
               st_d     = GUARD;
            end
            // A sync on the final clock still lets the slot end pulse out.
            if (commit_sync) begin
               id_d    = f_sid;
               cnt_d   = 32'd0;
               lost_d  = 1'b0;
               start_d = 1'b1;
               st_d    = ACTIVE;
            end
         end
         GUARD: begin
            cnt_d = cnt_q + 32'd1;
            if (commit_sync) begin
               id_d    = f_sid;
               cnt_d   = 32'd0;
               lost_d  = 1'b0;
               start_d = 1'b1;
               st_d    = ACTIVE;
            end else if (cnt_q == GRD_LAST) begin
               id_d    = id_q + 8'd1;
               cnt_d   = 32'd0;
               lost_d  = 1'b1;
               start_d = 1'b1;
               st_d    = ACTIVE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         prs_q     <= HDR0;
         dst_ok_q  <= 1'b0;
         type_ok_q <= 1'b0;
         op_q      <= 8'd0;
         sid_q     <= 8'd0;
         err_q     <= 16'd0;
         st_q      <= IDLE;
         cnt_q     <= 32'd0;
         id_q      <= 8'd0;
         sim_q     <= 1'b0;
         lost_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         prs_q     <= prs_d;
         dst_ok_q  <= dst_ok_d;
         type_ok_q <= type_ok_d;
         op_q      <= op_d;
         sid_q     <= sid_d;
         err_q     <= err_d;
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         sim_q     <= sim_d;
         lost_q    <= lost_d;
         start_q   <= start_d;
      end
   end

   assign o_sim_start     = sim_q;
   assign o_slot_id       = id_q;
   assign o_slot_start    = start_q;
   assign o_slot_end      = slot_end;
   assign o_tx_en         = (st_q == ACTIVE);
   assign o_sync_lost     = lost_q;
   assign o_frame_err_cnt = err_q;

endmodule

// File: tb/tb_tor_slot_sync_rx.sv
// Randomized scoreboard bench for tor_slot_sync_rx: a timeline model predicts
// slot pulses and window state; a monitor compares them as the DUT shows them.
module tb_tor_slot_sync_rx;

   localparam int LEN = 'h832;
   localparam int GAP = 'h7D + 'h10;
   localparam logic [47:0] MY  = 48'h8D_BC_5C_4A_00_00;
   localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OTH = 48'h8D_BC_5C_4A_05_00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] data = '0;
   logic [7:0]  keep = '0;
   logic        valid = 1'b0;
   logic        last = 1'b0;
   logic        user = 1'b0;
   logic        sim, sstart, send_p, tx, lost;
   logic [7:0]  sid;
   logic [15:0] errc;

   tor_slot_sync_rx dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rx_axis_data(data), .i_rx_axis_keep(keep),
      .i_rx_axis_valid(valid), .i_rx_axis_last(last),
      .i_rx_axis_user(user),
      .o_sim_start(sim), .o_slot_id(sid),
      .o_slot_start(sstart), .o_slot_end(send_p),
      .o_tx_en(tx), .o_sync_lost(lost),
      .o_frame_err_cnt(errc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 SIM_START, 1 TIME_SYNC, 2 counted error
   typedef struct {int n; int kind; logic [7:0] id;} cmt_t;
   typedef struct {int c; bit is_end; logic [7:0] id; logic lost;} ev_t;
   cmt_t cq[$];
   ev_t  eq[$];

   int n_chk = 0;
   int n_fail = 0;

   // Timeline model: phase 0 idle, 1 waiting for sync, 2 running.
   int          m_phase = 0;
   int          m_s = 0;
   logic [7:0]  m_id = '0;
   logic        m_lost = 1'b0;
   logic        m_sim = 1'b0;
   logic        m_tx = 1'b0;
   logic [15:0] m_err = '0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   always @(posedge clk) begin
      logic rs;
      cmt_t e;
      rs = rst_n;
      #2;
      if (!rs) begin
         m_phase = 0; m_s = 0; m_id = '0;
         m_lost = 0; m_sim = 0; m_err = '0;
      end else begin
         while (cq.size() > 0 && cq[0].n <= cyc) begin
            e = cq.pop_front();
            if (e.kind == 0) begin
               if (m_phase == 0) begin
                  m_sim = 1; m_phase = 1;
               end
            end else if (e.kind == 1) begin
               if (m_phase != 0) begin
                  m_phase = 2; m_s = cyc; m_id = e.id; m_lost = 0;
               end
            end else if (m_err != 16'hFFFF) begin
               m_err = m_err + 16'd1;
            end
         end
         if (m_phase == 2 && cyc == m_s + LEN + GAP) begin
            m_s = cyc; m_id = m_id + 8'd1; m_lost = 1;
         end
         if (m_phase == 2 && cyc == m_s)
            eq.push_back('{c: cyc, is_end: 0, id: m_id, lost: m_lost});
         if (m_phase == 2 && cyc == m_s + LEN - 1)
            eq.push_back('{c: cyc, is_end: 1, id: m_id, lost: m_lost});
      end
      m_tx = (m_phase == 2) && (cyc - m_s < LEN);
   end

   always @(negedge clk) begin
      ev_t e;
      if (cyc > 0) begin
         while (eq.size() > 0 && eq[0].c < cyc) begin
            e = eq.pop_front();
            n_chk++; n_fail++;
            $display("FAIL missed_pulse: got none expected end=%0d at %0d",
                     e.is_end, e.c);
         end
         chk("state", {37'd0, tx, sim, lost, sid, errc},
             {37'd0, m_tx, m_sim, m_lost, m_id, m_err});
         if (sstart) begin
            if (eq.size() == 0 || eq[0].is_end) begin
               n_chk++; n_fail++;
               $display("FAIL slot_start @%0d: got pulse expected none", cyc);
            end else begin
               e = eq.pop_front();
               chk("slot_start", {23'd0, cyc[31:0], sid, lost},
                   {23'd0, e.c[31:0], e.id, e.lost});
            end
         end
         if (send_p) begin
            if (eq.size() == 0 || !eq[0].is_end) begin
               n_chk++; n_fail++;
               $display("FAIL slot_end @%0d: got pulse expected none", cyc);
            end else begin
               e = eq.pop_front();
               chk("slot_end", {23'd0, cyc[31:0], sid, lost},
                   {23'd0, e.c[31:0], e.id, e.lost});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   // kind 3 = silently dropped, nothing expected
   task automatic send(input logic [47:0] dst, input logic [15:0] et,
                       input logic [7:0] op, input logic [7:0] id,
                       input logic usr, input int nb, input bit gaps,
                       input int kind);
      for (int i = 0; i < nb; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               valid = 0;
               data = {$urandom, $urandom};
               tick();
            end
         end
         if (i == 0) data = {dst, 16'h0A1B};
         else if (i == 1) data = {32'h2C3D_4E5F, et, op, id};
         else data = {$urandom, $urandom};
         valid = 1;
         last = (i == nb - 1);
         user = last ? usr : 1'($urandom);
         keep = (last && i == 1) ? 8'hFF : 8'($urandom);
         tick();
      end
      valid = 0; last = 0; user = 0;
      if (kind < 3) cq.push_back('{n: cyc, kind: kind, id: id});
      tick();
   endtask

   task automatic sync(input logic [7:0] id, input bit gaps);
      send($urandom_range(0, 1) ? MY : BC, 16'h88B5, 8'h02, id, 0,
           2 + $urandom_range(0, 3), gaps, 1);
   endtask

   task automatic sync2(input logic [7:0] id);
      send(MY, 16'h88B5, 8'h02, id, 0, 2, 0, 1);
   endtask

   task automatic err_frame(input int t);
      if (t == 0) send(MY, 16'h88B5, 8'h02, 8'h44, 1, 3, 1, 2);
      else if (t == 1) send(BC, 16'h0800, 8'h02, 8'h44, 0, 2, 1, 2);
      else if (t == 2) send(MY, 16'h88B5, 8'h07, 8'h44, 0, 4, 1, 2);
      else if (t == 3) send(MY, 16'h88B5, 8'h02, 8'h44, 0, 1, 1, 2);
      else if (t == 4) send(OTH, 16'h88B5, 8'h02, 8'h44, 0, 2, 1, 3);
      else send(OTH, 16'h88B5, 8'h01, 8'h44, 1, 1, 1, 3);
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1;
      repeat (2) tick();
      sync(8'h11, 1);
      repeat (4) tick();
      send(MY, 16'h88B5, 8'h01, 8'h00, 0, 3, 1, 0);
      repeat (20) tick();
      send(BC, 16'h88B5, 8'h01, 8'h00, 0, 2, 1, 0);
      repeat (10) tick();
      sync(8'h03, 1);
      wait_until(m_s + LEN + GAP + 5);
      wait_until(m_s + LEN + 3);
      sync2(8'h05);
      repeat (20) tick();
      for (int i = 0; i < 6; i++) err_frame(i);
      repeat (4) err_frame($urandom_range(0, 5));
      wait_until(m_s + 'h100 - 3);
      sync2(8'h09);
      wait_until(m_s + LEN - 2);
      sync2(8'($urandom));
      wait_until(m_s + LEN + 2);
      sync(8'hFF, 1);
      wait_until(m_s + LEN + GAP + 3);
      for (int k = 0; k < 5; k++) begin
         wait_until(m_s + $urandom_range(0, LEN + GAP + 40));
         if ($urandom_range(0, 1) == 1) err_frame($urandom_range(0, 5));
         sync(8'($urandom), 1);
      end
      wait_until(m_s + 50);
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
      repeat (5) tick();
      send(MY, 16'h88B5, 8'h01, 8'h00, 0, 2, 1, 0);
      repeat (5) tick();
      chk("pending_events", 64'(eq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tor_slot_sync_rx.md
# tor_slot_sync_rx

ToR-side receiver for the OCS controller's control channel. Parses control frames arriving on the ToR's control GT lane (the lane cabled to the OCS controller), latches the simulation-start command, and rebuilds the slot schedule locally from TIME_SYNC frames. It drives slot_id, slot boundary pulses and the transmit-enable window that gate the uplink VLB schedulers. If sync frames stop arriving, it free-runs on the controller's slot timing.

## Interface
- P_MY_TOR_MAC, 48'h8D_BC_5C_4A_00_00, this ToR's MAC; frames to it or to broadcast 48'hFFFF_FFFF_FFFF are accepted.
- P_CTRL_TYPE, 16'h88B5, ethertype of controller frames.
- P_SLOT_LEN, 32'h0000_0832, active slot length in clocks.
- P_CONFIG_DELAY, 32'h0000_007D, OCS reconfiguration guard length in clocks.
- P_SYNC_MARGIN, 32'h0000_0010, extra clocks tolerated past the guard before sync is declared lost.
- i_clk  in  1  user clock of the control GT lane.
- i_rst_n  in  1  synchronous, active-low reset.
- i_rx_axis_data  in  64  frame data; byte 0 = bits[63:56].
- i_rx_axis_keep  in  8  byte enables (ignored except on last).
- i_rx_axis_valid  in  1  beat valid; there is no backpressure.
- i_rx_axis_last  in  1  last beat of frame.
- i_rx_axis_user  in  1  frame error, sampled with last.
- o_sim_start  out  1  sticky level, set by SIM_START.
- o_slot_id  out  8  current slot id.
- o_slot_start  out  1  one-cycle pulse at the first clock of a slot.
- o_slot_end  out  1  one-cycle pulse at the last active clock of a slot.
- o_tx_en  out  1  high while the slot is active; uplinks may send only while it is high.
- o_sync_lost  out  1  sticky until the next valid TIME_SYNC.
- o_frame_err_cnt  out  16  count of discarded frames; saturates.

## Operation
- Frame format:
  - beat0[63:16] = dst MAC; beat0[15:0] = src MAC[47:32].
  - beat1[63:32] = src MAC[31:0]; beat1[31:16] = ethertype; beat1[15:8] = opcode; beat1[7:0] = slot id.
  - Later beats are padding and are ignored.
- Opcodes: 8'h01 = SIM_START, 8'h02 = TIME_SYNC.
- Parser FSM: HDR0 -> HDR1 -> PAD -> HDR0.
  - HDR0 captures the dst-MAC match on the first valid beat.
  - HDR1 captures ethertype, opcode and slot id.
  - PAD waits for last.
  - A last beat in HDR0 (1-beat frame) is discarded.
- A frame commits on its last beat only if all of these hold: dst matches, ethertype matches, opcode is known, i_rx_axis_user = 0.
  - Frames that fail on user, ethertype, length or opcode increment o_frame_err_cnt.
  - A dst-MAC mismatch is silently dropped and not counted.
- Slot FSM states: IDLE, WAIT_SYNC, ACTIVE, GUARD.
  - IDLE: a committed SIM_START sets o_sim_start -> WAIT_SYNC. A TIME_SYNC committed in IDLE is ignored.
  - WAIT_SYNC: a committed TIME_SYNC loads o_slot_id from the frame, clears the counter -> ACTIVE.
  - ACTIVE: o_tx_en = 1 and the counter increments. When counter = P_SLOT_LEN-1: pulse o_slot_end -> GUARD with the counter cleared.
  - GUARD: o_tx_en = 0.
    - A committed TIME_SYNC loads its slot id -> ACTIVE and clears o_sync_lost.
    - If the counter reaches P_CONFIG_DELAY+P_SYNC_MARGIN-1 with no sync: set o_sync_lost, o_slot_id += 1 (8-bit wrap, FF->00) -> ACTIVE.
  - TIME_SYNC committed while ACTIVE: resynchronise. Load the slot id, clear the counter, pulse o_slot_start, stay ACTIVE. No o_slot_end is issued for the truncated slot.
- o_slot_start pulses on every entry to ACTIVE and on every resync.
- A duplicate SIM_START has no effect.
- Counter is 32 bits; it never wraps because it is always cleared before reaching its compare values.

## Timing
- Reset values: o_sim_start=0, o_slot_id=0, o_slot_start=0, o_slot_end=0, o_tx_en=0, o_sync_lost=0, o_frame_err_cnt=0. Both FSMs reset to HDR0 / IDLE.
- Reset asserted mid-frame or mid-slot: all of the above takes effect on the next clock. The partial frame is dropped and not counted.
- Commit latency: the effect is registered 1 clock after the last beat.
  - o_sim_start, or o_slot_start together with o_tx_en, rises on cycle L+1, where L is the cycle of the last beat.
- Slot length: o_tx_en is high for exactly P_SLOT_LEN clocks. o_slot_end coincides with the final high clock.
- Free-run gap: o_tx_en is low for exactly P_CONFIG_DELAY+P_SYNC_MARGIN clocks.
- A sync commit on the same cycle as the ACTIVE->GUARD transition: the sync wins. Next state is ACTIVE with the counter cleared, o_slot_end still pulses, and o_slot_start pulses on the following cycle.
- Invalid beats (valid=0) are ignored; the parser holds its state.

## Test plan
- Reset, then SIM_START to P_MY_TOR_MAC -> o_sim_start=1 on cycle L+1; o_tx_en stays 0.
- TIME_SYNC with slot id 8'h03 -> o_slot_id=3 and an o_slot_start pulse on L+1. o_tx_en is high for 0x832 clocks, o_slot_end fires on its last clock, then o_tx_en is low.
- With no further sync -> after 0x7D+0x10 clocks: o_sync_lost=1, o_slot_id=4, o_slot_start pulses. Next sync with id 8'h05 -> o_sync_lost=0, o_slot_id=5.
- Sync error path: TIME_SYNC with i_rx_axis_user=1 on last -> state unchanged, o_frame_err_cnt=1. A frame to MAC ..._05_00 -> ignored, counter unchanged.
- Wrap: free-run from slot id FF -> o_slot_id becomes 00.
- Resync mid-ACTIVE at counter 0x100 with id 8'h09 -> o_slot_id=9, o_slot_start pulses, counter cleared, no o_slot_end. Reset asserted mid-slot -> all outputs return to 0 on the next clock.
